// File: rtl/multi_cycle_controller.sv
// ---------------------------------------------------------------------------
// multi_cycle_controller
//   Moore FSM that sequences the multi-cycle Yu Core datapath. The datapath has
//   one shared memory port, one ALU and one PC. Each instruction steps through
//   fetch / decode / execute / memory / writeback states. Memory accesses stall
//   until memReady is seen.
//
//   Optional feature: define ILLEGAL_TRAP_EN to route an unknown opcode to a
//   TRAP state and set the sticky illegalInstr flag. Without it, an unknown
//   opcode retires as a NOP from DECODE.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   synchronous active-low reset
//   opcode[6:0]  in   instr[6:0] from the instruction register
//   zero         in   ALU zero flag
//   memReady     in   memory completes the current request this cycle
//   pcWrite      out  PC load enable
//   adrSrc       out  memory address select (0 PC, 1 ALU result reg)
//   memRead      out  memory read request
//   memWrite     out  memory write request
//   irWrite      out  load instruction register and oldPC
//   resultSrc    out  result mux (00 ALUOut, 01 data reg, 10 ALU result)
//   ALUSrcA      out  ALU A mux (00 PC, 01 oldPC, 10 rs1)
//   ALUSrcB      out  ALU B mux (00 rs2, 01 imm, 10 const 4)
//   ALUOpcode    out  ALU decoder op (00 add, 01 sub, 10 funct-decoded)
//   immSrc       out  immediate format (I/load 00, S 01, B 10)
//   regWrite     out  register file write enable
//   instrDone    out  one-cycle pulse in the last state of an instruction
//   illegalInstr out  sticky illegal-opcode flag (0 unless ILLEGAL_TRAP_EN)
//   dbg_state    out  current FSM state, for observation only
//
// Memory handshake: a request (memRead or memWrite) and its address select
// are held for as long as the FSM stays in the requesting state. The FSM stays
// there until memReady is sampled high, which completes the transfer in that
// cycle. memReady is ignored in every other state.
// ---------------------------------------------------------------------------
module multi_cycle_controller #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [6:0]         opcode,
  input  logic               zero,
  input  logic               memReady,
  output logic               pcWrite,
  output logic               adrSrc,
  output logic               memRead,
  output logic               memWrite,
  output logic               irWrite,
  output logic [1:0]         resultSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUOpcode,
  output logic [1:0]         immSrc,
  output logic               regWrite,
  output logic               instrDone,
  output logic               illegalInstr,
  output logic [STATE_W-1:0] dbg_state
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_TRAP
  } state_t;

  state_t state;
  logic   known_op;
  logic   pc_update;
  logic   branch;

  assign known_op = (opcode == OP_LOAD) || (opcode == OP_STORE) ||
                    (opcode == OP_R)    || (opcode == OP_I)     ||
                    (opcode == OP_BRANCH);

  assign dbg_state = state;

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q;
  assign illegalInstr = illegal_q;
`else
  assign illegalInstr = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_FETCH;
`ifdef ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      case (state)
        S_FETCH:    if (memReady) state <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_LOAD, OP_STORE: state <= S_MEMADR;
            OP_R:              state <= S_EXECR;
            OP_I:              state <= S_EXECI;
            OP_BRANCH:         state <= S_BEQ;
            default: begin
`ifdef ILLEGAL_TRAP_EN
              state     <= S_TRAP;
              illegal_q <= 1'b1;
`else
              state <= S_FETCH;
`endif
            end
          endcase
        end
        S_MEMADR: begin
          if (opcode == OP_LOAD)       state <= S_MEMREAD;
          else if (opcode == OP_STORE) state <= S_MEMWRITE;
          else                         state <= S_FETCH;
        end
        S_MEMREAD:  if (memReady) state <= S_MEMWB;
        S_MEMWB:    state <= S_FETCH;
        S_MEMWRITE: if (memReady) state <= S_FETCH;
        S_EXECR:    state <= S_ALUWB;
        S_EXECI:    state <= S_ALUWB;
        S_ALUWB:    state <= S_FETCH;
        S_BEQ:      state <= S_FETCH;
`ifdef ILLEGAL_TRAP_EN
        S_TRAP:     state <= S_TRAP;   // only reset leaves TRAP
`endif
        default:    state <= S_FETCH;  // unused encodings recover
      endcase
    end
  end

  // Outputs depend on the state register only. The exceptions are the
  // memReady-qualified strobes in FETCH/MEMWRITE, pcWrite in BEQ (zero), the
  // unknown-opcode NOP retire in DECODE, and immSrc, which follows opcode.
  // While rst_n is low, every strobe and select is forced to zero, so an
  // outstanding request drops in the same cycle that reset is asserted.
  always_comb begin
    pc_update = 1'b0;
    branch    = 1'b0;
    adrSrc    = 1'b0;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    irWrite   = 1'b0;
    resultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUOpcode = 2'b00;
    immSrc    = 2'b00;
    regWrite  = 1'b0;
    instrDone = 1'b0;
    pcWrite   = 1'b0;

    case (state)
      S_FETCH: begin
        memRead   = 1'b1;
        ALUSrcB   = 2'b10;
        resultSrc = 2'b10;
        irWrite   = memReady;
        pc_update = memReady;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
`ifndef ILLEGAL_TRAP_EN
        instrDone = !known_op;
`endif
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: begin
        adrSrc  = 1'b1;
        memRead = 1'b1;
      end
      S_MEMWB: begin
        resultSrc = 2'b01;
        regWrite  = 1'b1;
        instrDone = 1'b1;
      end
      S_MEMWRITE: begin
        adrSrc    = 1'b1;
        memWrite  = 1'b1;
        instrDone = memReady;
      end
      S_EXECR: begin
        ALUSrcA   = 2'b10;
        ALUOpcode = 2'b10;
      end
      S_EXECI: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ALUOpcode = 2'b10;
      end
      S_ALUWB: begin
        regWrite  = 1'b1;
        instrDone = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA   = 2'b10;
        ALUOpcode = 2'b01;
        branch    = 1'b1;
        instrDone = 1'b1;
      end
      default: ;
    endcase

    pcWrite = pc_update | (branch & zero);

    case (opcode)
      OP_STORE:  immSrc = 2'b01;
      OP_BRANCH: immSrc = 2'b10;
      default:   immSrc = 2'b00;
    endcase

    if (!rst_n) begin
      pcWrite   = 1'b0;
      adrSrc    = 1'b0;
      memRead   = 1'b0;
      memWrite  = 1'b0;
      irWrite   = 1'b0;
      resultSrc = 2'b00;
      ALUSrcA   = 2'b00;
      ALUSrcB   = 2'b00;
      ALUOpcode = 2'b00;
      immSrc    = 2'b00;
      regWrite  = 1'b0;
      instrDone = 1'b0;
    end
  end

endmodule

// File: tb/tb_multi_cycle_controller.sv
// ---------------------------------------------------------------------------
// tb_multi_cycle_controller
//   Directed bench for multi_cycle_controller. Each cycle, the driver applies
//   inputs shortly after the rising edge. It pushes the hand-computed output
//   vector for that cycle into exp_q. The monitor pops one entry on every
//   falling edge and compares it with the DUT outputs.
//   Vector layout (MSB..LSB): pcWrite adrSrc memRead memWrite irWrite
//   resultSrc[2] ALUSrcA[2] ALUSrcB[2] ALUOpcode[2] immSrc[2] regWrite
//   instrDone illegalInstr.
// ---------------------------------------------------------------------------
module tb_multi_cycle_controller;

  localparam int W = 18;

  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] ROP    = 7'b0110011;
  localparam logic [6:0] IOP    = 7'b0010011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] BAD    = 7'b1111111;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] opcode = LOAD;
  logic       zero = 1'b0;
  logic       memReady = 1'b0;
  logic       pcWrite, adrSrc, memRead, memWrite, irWrite;
  logic [1:0] resultSrc, ALUSrcA, ALUSrcB, ALUOpcode, immSrc;
  logic       regWrite, instrDone, illegalInstr;
  logic [3:0] dbg_state;

  multi_cycle_controller #(.STATE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
    .memReady(memReady), .pcWrite(pcWrite), .adrSrc(adrSrc),
    .memRead(memRead), .memWrite(memWrite), .irWrite(irWrite),
    .resultSrc(resultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOpcode(ALUOpcode), .immSrc(immSrc), .regWrite(regWrite),
    .instrDone(instrDone), .illegalInstr(illegalInstr), .dbg_state(dbg_state)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int           n_vec = 0;
  int           n_err = 0;

  function automatic logic [W-1:0] ev(
      input logic pcw, input logic adr, input logic mrd, input logic mwr,
      input logic irw, input logic [1:0] rs, input logic [1:0] sa,
      input logic [1:0] sb, input logic [1:0] aop, input logic [1:0] imm,
      input logic rw, input logic done, input logic ill);
    return {pcw, adr, mrd, mwr, irw, rs, sa, sb, aop, imm, rw, done, ill};
  endfunction

  // Expected output vectors for each state, written out from the state table.
  function automatic logic [W-1:0] x_fetch(input logic rdy, input logic [1:0] imm);
    return ev(rdy, 1'b0, 1'b1, 1'b0, rdy, 2'b10, 2'b00, 2'b10, 2'b00, imm, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [W-1:0] x_decode(input logic [1:0] imm, input logic done);
    return ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, imm, 1'b0, done, 1'b0);
  endfunction
  function automatic logic [W-1:0] x_memadr(input logic [1:0] imm);
    return ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, imm, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [W-1:0] x_memread();
    return ev(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [W-1:0] x_memwb();
    return ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
  endfunction
  function automatic logic [W-1:0] x_memwrite(input logic rdy);
    return ev(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0, rdy, 1'b0);
  endfunction
  function automatic logic [W-1:0] x_exec(input logic [1:0] sb);
    return ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, sb, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [W-1:0] x_aluwb();
    return ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
  endfunction
  function automatic logic [W-1:0] x_beq(input logic z);
    return ev(z, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b01, 2'b10, 1'b0, 1'b1, 1'b0);
  endfunction

  // driver task: one clock cycle of stimulus plus its expected outputs
  task automatic step(input logic r, input logic [6:0] op, input logic z,
                      input logic rdy, input logic [W-1:0] e, input string tag);
    @(posedge clk);
    #1;
    rst_n    = r;
    opcode   = op;
    zero     = z;
    memReady = rdy;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // monitor
  logic [W-1:0] act;
  assign act = {pcWrite, adrSrc, memRead, memWrite, irWrite, resultSrc, ALUSrcA,
                ALUSrcB, ALUOpcode, immSrc, regWrite, instrDone, illegalInstr};

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      string        t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      n_vec++;
      if (act !== e) begin
        n_err++;
        $display("FAIL %s: got %b expected %b (t=%0t)", t, act, e, $time);
      end
    end
  end

  initial begin
    // reset: strobes and selects are forced low even with memReady high
    step(1'b0, LOAD, 1'b0, 1'b1, '0, "reset0");
    step(1'b0, LOAD, 1'b0, 1'b1, '0, "reset1");
    step(1'b0, STORE, 1'b1, 1'b1, '0, "reset2");

    // 1: LOAD with FETCH stalled 2 cycles and MEMREAD stalled 1 cycle
    step(1'b1, LOAD, 1'b0, 1'b0, x_fetch(1'b0, 2'b00), "ld_fetch_stall1");
    step(1'b1, LOAD, 1'b0, 1'b0, x_fetch(1'b0, 2'b00), "ld_fetch_stall2");
    step(1'b1, LOAD, 1'b0, 1'b1, x_fetch(1'b1, 2'b00), "ld_fetch_rdy");
    step(1'b1, LOAD, 1'b0, 1'b1, x_decode(2'b00, 1'b0), "ld_decode");
    step(1'b1, LOAD, 1'b0, 1'b1, x_memadr(2'b00), "ld_memadr");
    step(1'b1, LOAD, 1'b0, 1'b0, x_memread(), "ld_memread_stall");
    step(1'b1, LOAD, 1'b0, 1'b1, x_memread(), "ld_memread_rdy");
    step(1'b1, LOAD, 1'b0, 1'b0, x_memwb(), "ld_memwb_c8");

    // 2: STORE with memReady high, retires in 4 cycles
    step(1'b1, STORE, 1'b0, 1'b1, x_fetch(1'b1, 2'b01), "st_fetch");
    step(1'b1, STORE, 1'b0, 1'b1, x_decode(2'b01, 1'b0), "st_decode");
    step(1'b1, STORE, 1'b0, 1'b1, x_memadr(2'b01), "st_memadr");
    step(1'b1, STORE, 1'b0, 1'b1, x_memwrite(1'b1), "st_memwrite_c4");
    // STORE with one stall cycle in MEMWRITE
    step(1'b1, STORE, 1'b0, 1'b1, x_fetch(1'b1, 2'b01), "st2_fetch");
    step(1'b1, STORE, 1'b0, 1'b1, x_decode(2'b01, 1'b0), "st2_decode");
    step(1'b1, STORE, 1'b0, 1'b1, x_memadr(2'b01), "st2_memadr");
    step(1'b1, STORE, 1'b0, 1'b0, x_memwrite(1'b0), "st2_memwrite_stall");
    step(1'b1, STORE, 1'b0, 1'b1, x_memwrite(1'b1), "st2_memwrite_rdy");

    // 3: R then I-ALU; memReady noise outside memory states is ignored
    step(1'b1, ROP, 1'b0, 1'b1, x_fetch(1'b1, 2'b00), "r_fetch");
    step(1'b1, ROP, 1'b0, 1'b0, x_decode(2'b00, 1'b0), "r_decode");
    step(1'b1, ROP, 1'b0, 1'b1, x_exec(2'b00), "r_execr");
    step(1'b1, ROP, 1'b0, 1'b0, x_aluwb(), "r_aluwb");
    step(1'b1, IOP, 1'b0, 1'b1, x_fetch(1'b1, 2'b00), "i_fetch");
    step(1'b1, IOP, 1'b0, 1'b1, x_decode(2'b00, 1'b0), "i_decode");
    step(1'b1, IOP, 1'b0, 1'b1, x_exec(2'b01), "i_execi");
    step(1'b1, IOP, 1'b0, 1'b1, x_aluwb(), "i_aluwb");

    // 4: BRANCH taken (zero=1) then not taken (zero=0)
    step(1'b1, BRANCH, 1'b0, 1'b1, x_fetch(1'b1, 2'b10), "b1_fetch");
    step(1'b1, BRANCH, 1'b1, 1'b1, x_decode(2'b10, 1'b0), "b1_decode");
    step(1'b1, BRANCH, 1'b1, 1'b1, x_beq(1'b1), "b1_beq_taken");
    step(1'b1, BRANCH, 1'b1, 1'b1, x_fetch(1'b1, 2'b10), "b2_fetch");
    step(1'b1, BRANCH, 1'b1, 1'b1, x_decode(2'b10, 1'b0), "b2_decode");
    step(1'b1, BRANCH, 1'b0, 1'b1, x_beq(1'b0), "b2_beq_not_taken");

    // 5: illegal opcode
    step(1'b1, BAD, 1'b0, 1'b1, x_fetch(1'b1, 2'b00), "bad_fetch");
`ifdef ILLEGAL_TRAP_EN
    step(1'b1, BAD, 1'b0, 1'b1, x_decode(2'b00, 1'b0), "bad_decode");
    step(1'b1, BAD, 1'b0, 1'b1,
         ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1),
         "trap_hold1");
    step(1'b1, BAD, 1'b0, 1'b1,
         ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1),
         "trap_hold2");
    step(1'b0, BAD, 1'b0, 1'b1,
         ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1),
         "trap_reset");
`else
    step(1'b1, BAD, 1'b0, 1'b1, x_decode(2'b00, 1'b0) | W'(2), "bad_decode_nop");
`endif

    // 6: reset during a stalled MEMREAD, then restart from FETCH
    step(1'b1, LOAD, 1'b0, 1'b1, x_fetch(1'b1, 2'b00), "rs_fetch");
    step(1'b1, LOAD, 1'b0, 1'b1, x_decode(2'b00, 1'b0), "rs_decode");
    step(1'b1, LOAD, 1'b0, 1'b1, x_memadr(2'b00), "rs_memadr");
    step(1'b1, LOAD, 1'b0, 1'b0, x_memread(), "rs_memread_stall");
    step(1'b0, LOAD, 1'b0, 1'b0, '0, "rs_req_drop");
    step(1'b1, LOAD, 1'b0, 1'b0, x_fetch(1'b0, 2'b00), "rs_refetch_stall");
    step(1'b1, LOAD, 1'b0, 1'b1, x_fetch(1'b1, 2'b00), "rs_refetch_rdy");
    step(1'b1, LOAD, 1'b0, 1'b1, x_decode(2'b00, 1'b0), "rs2_decode");
    step(1'b1, LOAD, 1'b0, 1'b1, x_memadr(2'b00), "rs2_memadr");
    step(1'b1, LOAD, 1'b0, 1'b1, x_memread(), "rs2_memread");
    step(1'b1, LOAD, 1'b0, 1'b1, x_memwb(), "rs2_memwb");

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d vectors left in queue, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
